reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter XLEN, default 32: data width in bits, multiple of 8.
REQ-002 Parameter DEPTH, default 32: number of registers, 2..1024.
REQ-003 Parameter AW, default $clog2(DEPTH): address width, derived, not overridden.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 always reads zero.
REQ-005 Parameter BYPASS, default 1: when 1, same-cycle writes forward to the read ports.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 RST_N  in  1  reset, asynchronous, active-low.
REQ-008 WE3  in  1  write enable, port 3.
REQ-009 A1, A2  in  AW  read addresses, ports 1 and 2.
REQ-010 A3  in  AW  write address.
REQ-011 WD3  in  XLEN  write data.
REQ-012 BE3  in  XLEN/8  write byte enables, bit i covers WD3[8i+7:8i].
REQ-013 CLR  in  1  synchronous request to zero the whole array.
REQ-014 RD1, RD2  out  XLEN  read data, combinational from address.
REQ-015 READY  out  1  array valid, writes accepted.

Function
REQ-016 The FSM SHALL have two states: ST_CLEAR and ST_IDLE.
REQ-017 In ST_CLEAR, a counter 0..DEPTH-1 SHALL zero one entry per cycle; on the edge that writes DEPTH-1, the FSM SHALL go to ST_IDLE.
REQ-018 READY SHALL be 1 only in ST_IDLE, so READY rises exactly DEPTH cycles after the first edge with RST_N=1.
REQ-019 CLR=1 in ST_IDLE SHALL move the FSM to ST_CLEAR with counter 0 on the next edge.
REQ-020 CLR=1 in ST_CLEAR SHALL restart the counter at 0.
REQ-021 A write SHALL be accepted iff WE3=1, READY=1, CLR=0, A3<DEPTH and not (ZERO_REG=1 and A3=0).
REQ-022 An accepted write SHALL update only the bytes with BE3 set, on the rising edge; a write with BE3=0 leaves the entry unchanged.
REQ-023 If CLR and WE3 are both 1 in ST_IDLE, CLR SHALL win and the write is discarded.
REQ-024 RDn SHALL read 0 when READY=0, when An>=DEPTH, or when ZERO_REG=1 and An=0.
REQ-025 Otherwise, with BYPASS=1 and an accepted write to An in the same cycle, RDn SHALL equal the stored word with the enabled WD3 bytes merged in.
REQ-026 Otherwise, RDn SHALL equal the stored word.
REQ-027 With BYPASS=0, RDn SHALL show new data only after the write edge.
REQ-028 Both read ports SHALL be independent; A1=A2 is legal and returns identical data.

Reset
REQ-029 RST_N=0 SHALL asynchronously force ST_CLEAR, counter 0 and READY=0, so RD1=RD2=0.
REQ-030 The array itself SHALL NOT be reset asynchronously; the clear sweep zeroes it.
REQ-031 Reset asserted mid-sweep or mid-write SHALL abort the operation; the sweep restarts from 0 after release.

Structure
REQ-032 Package reg_file_pkg SHALL hold the state typedef (ST_CLEAR, ST_IDLE) and the default constants XLEN_DEF=32 and DEPTH_DEF=32.
REQ-033 Sub-module reg_file_clr_ctrl SHALL contain the FSM and sweep counter, and output READY, clr_we and clr_adr.
REQ-034 The array SHALL be an unpacked XLEN-wide memory with one write port, muxed between the sweep and port 3.

Verification
REQ-035 Reset release, default parameters: READY=0 for 32 cycles, then 1; RD1 and RD2 read 0 at every address.
REQ-036 Write 228 to A3=10 with BE3=4'hF, then read with A1=10: RD1=228 in the same cycle (bypass) and on the next cycle.
REQ-037 Write 1337 to 21, then BE3=4'b0001 with WD3=32'hFF: RD2 at 21 reads 32'h000005FF.
REQ-038 Write 30 to A3=0 with ZERO_REG=1: RD1 at 0 reads 0; with DEPTH=20, a write to 25 is ignored and a read of 25 returns 0.
REQ-039 Pulse CLR during a write of 1488 to address 5: the write is discarded, READY=0 for 32 cycles, then every entry reads 0.
REQ-040 Drop RST_N at sweep count 12: READY=0 immediately; after release the full 32-cycle sweep repeats.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
// The clear controller and the array top both import this package.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Clear-sweep controller: zeroes one entry per cycle after reset or a clr request.
// ready and clr_we are registered and always complement each other.
module reg_file_clr_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_adr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_e     state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            ready  <= 1'b0;
            clr_we <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        ready  <= 1'b1;
                        clr_we <= 1'b0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state  <= ST_CLEAR;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        clr_we <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_CLEAR;
                    cnt    <= '0;
                    ready  <= 1'b0;
                    clr_we <= 1'b1;
                end
            endcase
        end
    end

    assign clr_adr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Two-read / one-write register file with byte enables, optional hard-wired
// zero register, optional write-to-read bypass and a sweeping clear.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    input  logic [AW-1:0]     a3,
    input  logic [XLEN-1:0]   wd3,
    input  logic [XLEN/8-1:0] be3,
    input  logic              clr,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic              ready
);

    localparam int          NB      = XLEN / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];

    logic            clr_we;
    logic [AW-1:0]   clr_adr;
    logic            wr_acc;
    logic [XLEN-1:0] wr_word;
    logic [1:0][AW-1:0]   ra;
    logic [1:0][XLEN-1:0] rd;

    reg_file_clr_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_clr_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_adr (clr_adr)
    );

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // clr beats a concurrent write; writes are only taken once the sweep is done.
    assign wr_acc = we3 && ready && !clr && in_range(a3) && !is_zero_reg(a3);

    always_comb begin
        wr_word = in_range(a3) ? mem[a3] : '0;
        for (int i = 0; i < NB; i++) begin
            if (be3[i]) wr_word[8*i +: 8] = wd3[8*i +: 8];
        end
    end

    // Single write port: sweep and port 3 are mutually exclusive via ready.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_adr] <= '0;
        end else if (wr_acc) begin
            mem[a3] <= wr_word;
        end
    end

    assign ra[0] = a1;
    assign ra[1] = a2;

    always_comb begin
        rd = '0;
        for (int p = 0; p < 2; p++) begin
            if (ready && in_range(ra[p]) && !is_zero_reg(ra[p])) begin
                if ((BYPASS != 0) && wr_acc && (ra[p] == a3)) begin
                    rd[p] = wr_word;
                end else begin
                    rd[p] = mem[ra[p]];
                end
            end
        end
    end

    assign rd1 = rd[0];
    assign rd2 = rd[1];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: default DUT, a DEPTH=20 DUT and a no-bypass/no-zero-reg DUT
// share the same stimulus; expected values are hand-computed constants.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we3 = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0;
    logic [31:0] wd3 = '0;
    logic [3:0]  be3 = '0;
    logic [31:0] rd1, rd2, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        ready, ready_b, ready_c;

    int checks = 0;
    int failures = 0;
    int n, nb;

    always #5 clk = ~clk;

    reg_file_param dut_a (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .be3(be3), .clr(clr), .rd1(rd1), .rd2(rd2), .ready(ready)
    );

    reg_file_param #(.DEPTH(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .be3(be3), .clr(clr), .rd1(rd1_b), .rd2(rd2_b), .ready(ready_b)
    );

    reg_file_param #(.ZERO_REG(0), .BYPASS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
        .wd3(wd3), .be3(be3), .clr(clr), .rd1(rd1_c), .rd2(rd2_c), .ready(ready_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises on dut_a; bounded so a stuck sweep still ends.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
            if (ready_b && nb == 0) nb = cnt;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        a3 = a; wd3 = d; be3 = be; we3 = 1'b1;
        tick();
        we3 = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd1", rd1, 32'd0);

        // Reset release: sweep length of each DUT
        rst_n = 1'b1;
        nb = 0;
        wait_ready(n);
        chk("sweep_len_a", n, 32'd32);
        chk("sweep_len_b", nb, 32'd20);
        chk("ready_c", {31'd0, ready_c}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            chk("init_rd1", rd1, 32'd0);
            chk("init_rd2", rd2, 32'd0);
        end

        // Full-word write with bypass, and A1=A2
        a1 = 5'd10; a2 = 5'd10;
        a3 = 5'd10; wd3 = 32'd228; be3 = 4'hF; we3 = 1'b1;
        #1;
        chk("bypass_rd1", rd1, 32'd228);
        chk("nobypass_c", rd1_c, 32'd0);
        tick();
        we3 = 1'b0;
        #1;
        chk("after_rd1", rd1, 32'd228);
        chk("same_addr_rd2", rd2, 32'd228);
        chk("after_c", rd1_c, 32'd228);

        // Byte-enable merge
        wr(5'd21, 32'd1337, 4'hF);
        a2 = 5'd21;
        a3 = 5'd21; wd3 = 32'h0000_00FF; be3 = 4'b0001; we3 = 1'b1;
        #1;
        chk("be_bypass", rd2, 32'h0000_05FF);
        tick();
        we3 = 1'b0;
        #1;
        chk("be_merge", rd2, 32'h0000_05FF);
        wr(5'd21, 32'hAAAA_AAAA, 4'b0000);
        #1;
        chk("be_none", rd2, 32'h0000_05FF);

        // Zero register and out-of-range write
        a1 = 5'd0;
        wr(5'd0, 32'd30, 4'hF);
        #1;
        chk("zero_reg_a", rd1, 32'd0);
        chk("zero_reg_off_c", rd1_c, 32'd30);
        a1 = 5'd25;
        wr(5'd25, 32'd77, 4'hF);
        #1;
        chk("oor_read_b", rd1_b, 32'd0);
        chk("inrange_a", rd1, 32'd77);

        // CLR beats a concurrent write, then full re-sweep
        a1 = 5'd5;
        a3 = 5'd5; wd3 = 32'd1488; be3 = 4'hF; we3 = 1'b1; clr = 1'b1;
        #1;
        chk("clr_no_bypass", rd1, 32'd0);
        tick();
        we3 = 1'b0; clr = 1'b0;
        chk("clr_ready", {31'd0, ready}, 32'd0);
        a1 = 5'd10;
        #1;
        chk("clr_sweep_rd", rd1, 32'd0);
        wait_ready(n);
        chk("clr_sweep_len", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(i);
            #1;
            chk("clr_rd1", rd1, 32'd0);
            chk("clr_rd2_c", rd2_c, 32'd0);
        end

        // Async reset while idle, then mid-sweep
        wr(5'd3, 32'hDEAD_BEEF, 4'hF);
        a1 = 5'd3;
        #1;
        chk("pre_rst_rd", rd1, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("rst_idle_ready", {31'd0, ready}, 32'd0);
        chk("rst_idle_rd", rd1, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("mid_sweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ready(n);
        chk("resweep_len", n, 32'd32);
        #1;
        chk("resweep_rd", rd1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
